// File: rtl/cmp_bist_sequencer.sv
// BIST stimulus generator and response checker for the magnitude comparator.
// Optional build macro CMP_BIST_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module cmp_bist_sequencer #(
   parameter int WIDTH  = 2,
   parameter int SETTLE = 2,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             fail_valid,
   output logic [WIDTH-1:0] fail_a,
   output logic [WIDTH-1:0] fail_b
);

   localparam int IDX_W = 2 * WIDTH;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE_WAIT,
      CHECK,
      DONE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] settle_cnt;

   logic             mismatch;
   logic             last_vec;
   logic [ERR_W-1:0] err_next;

   // Any flag differing from the expected relation counts, so all-zero and
   // multi-hot responses are caught as well as plain wrong answers.
   always_comb begin
      mismatch = ({cmp_gt, cmp_eq, cmp_lt} !=
                  {a_out > b_out, a_out == b_out, a_out < b_out});
      last_vec = &idx;
      err_next = (&err_count) ? err_count : err_count + ERR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         a_out      <= '0;
         b_out      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_valid <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (state == DONE) begin
                  done <= 1'b1;
                  busy <= 1'b0;
                  pass <= (err_count == '0);
               end
               if (start) begin
                  state      <= DRIVE;
                  idx        <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_valid <= 1'b0;
                  fail_a     <= '0;
                  fail_b     <= '0;
               end
            end

            DRIVE: begin
               a_out      <= idx[IDX_W-1:WIDTH];
               b_out      <= idx[WIDTH-1:0];
               settle_cnt <= CNT_W'(SETTLE - 1);
               state      <= SETTLE_WAIT;
            end

            SETTLE_WAIT: begin
               if (settle_cnt == '0) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt - CNT_W'(1);
               end
            end

            CHECK: begin
               if (mismatch) begin
                  err_count <= err_next;
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_a     <= a_out;
                     fail_b     <= b_out;
                  end
               end
`ifdef CMP_BIST_STOP_ON_FAIL_EN
               if (mismatch || last_vec) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= DRIVE;
               end
`else
               if (last_vec) begin
                  state <= DONE;
               end else begin
                  idx   <= idx + IDX_W'(1);
                  state <= DRIVE;
               end
`endif
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_bist_sequencer.sv
// Self-checking bench: comparator modelled as a response table, sequencer results
// predicted from the table by counting vectors whose response differs from ideal.
module tb_cmp_bist_sequencer;

   localparam int W      = 2;
   localparam int NVEC   = 1 << (2 * W);
   localparam int SET    = 2;
   localparam int PERVEC = SET + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         cmp_gt, cmp_eq, cmp_lt;
   logic [W-1:0] a_out, b_out, fail_a, fail_b;
   logic         busy, done, pass, fail_valid;
   logic [7:0]   err_count;

   logic         s_gt, s_eq, s_lt;
   logic [W-1:0] s_a, s_b, s_fail_a, s_fail_b;
   logic         s_busy, s_done, s_pass, s_fail_valid;
   logic [1:0]   s_err_count;

   logic [2:0]   resp_tab [NVEC];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   assign {cmp_gt, cmp_eq, cmp_lt} = resp_tab[{a_out, b_out}];
   assign {s_gt, s_eq, s_lt}       = resp_tab[{s_a, s_b}];

   cmp_bist_sequencer #(.WIDTH(W), .SETTLE(SET), .ERR_W(8)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
      .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
   );

   cmp_bist_sequencer #(.WIDTH(W), .SETTLE(SET), .ERR_W(2)) u_sat (
      .clk(clk), .rst(rst), .start(start),
      .cmp_gt(s_gt), .cmp_eq(s_eq), .cmp_lt(s_lt),
      .a_out(s_a), .b_out(s_b), .busy(s_busy), .done(s_done), .pass(s_pass),
      .err_count(s_err_count), .fail_valid(s_fail_valid), .fail_a(s_fail_a), .fail_b(s_fail_b)
   );

   function automatic logic [2:0] ideal(input int i);
      int a, b;
      a = i / (1 << W);
      b = i % (1 << W);
      return {a > b, a == b, a < b};
   endfunction

   task automatic set_ideal();
      for (int i = 0; i < NVEC; i++) resp_tab[i] = ideal(i);
   endtask

   // Reference: number of wrong responses and index of the first one.
   task automatic model(output int nerr, output int first);
      nerr = 0;
      first = -1;
      for (int i = 0; i < NVEC; i++) begin
         if (resp_tab[i] !== ideal(i)) begin
            nerr++;
            if (first < 0) first = i;
         end
      end
   endtask

   task automatic run_sweep(input int extra_start_edge);
      int nerr, first, done_edge, e_err, e_sat, last_vec, vec;
      model(nerr, first);
`ifdef CMP_BIST_STOP_ON_FAIL_EN
      done_edge = (first >= 0) ? PERVEC * (first + 1) + 1 : NVEC * PERVEC + 1;
      e_err     = (first >= 0) ? 1 : 0;
      e_sat     = e_err;
      last_vec  = (first >= 0) ? first : NVEC - 1;
`else
      done_edge = NVEC * PERVEC + 1;
      e_err     = (nerr > 255) ? 255 : nerr;
      e_sat     = (nerr > 3) ? 3 : nerr;
      last_vec  = NVEC - 1;
`endif
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int n = 1; n <= done_edge; n++) begin
         @(negedge clk);
         start = (n == extra_start_edge - 1);
         if (n < done_edge) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               miscompares++;
               $display("FAIL sweep_busy edge %0d: busy=%b done=%b want busy=1 done=0", n, busy, done);
            end
            if (n % PERVEC == 2) begin
               vec = (n - 2) / PERVEC;
               vectors++;
               if ({a_out, b_out} !== vec[2*W-1:0]) begin
                  miscompares++;
                  $display("FAIL sweep_order edge %0d: a=%0d b=%0d want vector %0d", n, a_out, b_out, vec);
               end
            end
         end
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL done_edge %0d: done=%b busy=%b want done=1 busy=0", done_edge, done, busy);
      end
      vectors++;
      if (pass !== (e_err == 0)) begin
         miscompares++;
         $display("FAIL pass: got %b want %b", pass, (e_err == 0));
      end
      vectors++;
      if (err_count !== e_err[7:0]) begin
         miscompares++;
         $display("FAIL err_count: got %0d want %0d", err_count, e_err);
      end
      vectors++;
      if (s_err_count !== e_sat[1:0]) begin
         miscompares++;
         $display("FAIL err_count_sat: got %0d want %0d", s_err_count, e_sat);
      end
      vectors++;
      if (fail_valid !== (first >= 0)) begin
         miscompares++;
         $display("FAIL fail_valid: got %b want %b", fail_valid, (first >= 0));
      end
      vectors++;
      if (first >= 0 && {fail_a, fail_b} !== first[2*W-1:0]) begin
         miscompares++;
         $display("FAIL fail_vector: got a=%0d b=%0d want index %0d", fail_a, fail_b, first);
      end else if (first < 0 && {fail_a, fail_b} !== '0) begin
         miscompares++;
         $display("FAIL fail_vector: got a=%0d b=%0d want 0 0", fail_a, fail_b);
      end
      vectors++;
      if ({a_out, b_out} !== last_vec[2*W-1:0]) begin
         miscompares++;
         $display("FAIL final_vector: got a=%0d b=%0d want index %0d", a_out, b_out, last_vec);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      set_ideal();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if ({a_out, b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: a=%0d b=%0d busy=%b done=%b pass=%b err=%0d fv=%b fa=%0d fb=%0d want all 0",
                  a_out, b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b);
      end
   endtask

   task automatic test_ideal();
      set_ideal();
      run_sweep(-1);
   endtask

   task automatic test_eq_stuck();
      set_ideal();
      for (int i = 0; i < NVEC; i++) resp_tab[i][1] = 1'b0;
      run_sweep(-1);
   endtask

   task automatic test_swap();
      set_ideal();
      for (int i = 0; i < NVEC; i++) resp_tab[i] = {resp_tab[i][0], resp_tab[i][1], resp_tab[i][2]};
      run_sweep(-1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 6; t++) begin
         set_ideal();
         for (int i = 0; i < NVEC; i++)
            if ($urandom_range(3) == 0) resp_tab[i] = 3'($urandom_range(7));
         run_sweep(-1);
      end
   endtask

   task automatic test_reset_mid_sweep();
      set_ideal();
      for (int i = 0; i < NVEC; i++) resp_tab[i][1] = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int n = 1; n < 20; n++) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if ({a_out, b_out, busy, done, pass, err_count, fail_valid, fail_a, fail_b} !== '0 ||
          s_err_count !== 2'd0 || s_fail_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: a=%0d b=%0d busy=%b done=%b err=%0d fv=%b fa=%0d fb=%0d want all 0",
                  a_out, b_out, busy, done, err_count, fail_valid, fail_a, fail_b);
      end
      @(negedge clk);
      set_ideal();
      run_sweep(-1);
   endtask

   task automatic test_start_ignored();
      set_ideal();
      run_sweep(30);
   endtask

   task automatic test_back_to_back();
      set_ideal();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      vectors++;
      if (done !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL restart_done_clear: done=%b busy=%b want done=0 busy=1", done, busy);
      end
      @(negedge clk);
      vectors++;
      if (a_out !== '0 || b_out !== '0) begin
         miscompares++;
         $display("FAIL restart_vector: a=%0d b=%0d want 0 0", a_out, b_out);
      end
      for (int n = 2; n <= NVEC * PERVEC + 1; n++) @(negedge clk);
      vectors++;
      if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0) begin
         miscompares++;
         $display("FAIL restart_done: done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_eq_stuck();
      test_swap();
      test_random();
      test_reset_mid_sweep();
      test_start_ignored();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
